// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared sizes, types and idle constants for the LED matrix
// scanner (4 columns x 8 rows, all outputs active-low).
package led_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int ROW_BITS = 8;

  typedef logic [1:0]          col_idx_t;
  typedef logic [ROW_BITS-1:0] row_t;
  typedef logic [NUM_COLS-1:0] col_sel_t;

  // Active-low: all ones means every LED / column is off.
  localparam row_t     LEDS_OFF  = 8'hFF;
  localparam col_sel_t LCOL_NONE = 4'hF;

endpackage : led_scan_pkg

// File: rtl/led_scan_if.sv
// led_scan_if: row patterns from the status logic plus the row/column pin
// drive back to the board. The brightness input exists only when
// LEDSCAN_BRIGHTNESS_EN is defined.
interface led_scan_if;
  import led_scan_pkg::*;

  row_t     leds1;
  row_t     leds2;
  row_t     leds3;
  row_t     leds4;
  row_t     leds;
  col_sel_t lcol;
`ifdef LEDSCAN_BRIGHTNESS_EN
  logic [3:0] brightness;
`endif

  // Parent side: supplies patterns, observes the pin drive.
  modport master (
`ifdef LEDSCAN_BRIGHTNESS_EN
    output brightness,
`endif
    output leds1, leds2, leds3, leds4,
    input  leds, lcol
  );

  // Scanner side.
  modport slave (
`ifdef LEDSCAN_BRIGHTNESS_EN
    input  brightness,
`endif
    input  leds1, leds2, leds3, leds4,
    output leds, lcol
  );

endinterface : led_scan_if

// File: rtl/led_scan_timer.sv
// led_scan_timer: slot counter and column index for the LED scanner.
// cnt runs 0..COL_CYCLES-1; each wrap advances col (0,1,2,3,0...).
// slot_start is high on the cnt==0 cycle of every column slot.
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int COL_CYCLES = 3000
) (
  input  logic        clk12MHz,
  input  logic        reset,
  output col_idx_t    col,
  output logic [15:0] cnt,
  output logic        slot_start
);

  localparam logic [15:0] CNT_LAST = 16'(COL_CYCLES - 1);

  logic [15:0] cnt_reg, cnt_next;
  col_idx_t    col_reg, col_next;

  // Next-state: count up, wrap at end of slot and step to the next column.
  always_comb begin
    cnt_next = cnt_reg + 16'd1;
    col_next = col_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next = 16'd0;
      col_next = col_reg + col_idx_t'(1);
    end
  end

  // State register; reset restarts the scan at column 0, start of slot.
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      cnt_reg <= 16'd0;
      col_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      col_reg <= col_next;
    end
  end

  assign col        = col_reg;
  assign cnt        = cnt_reg;
  assign slot_start = (cnt_reg == 16'd0);

endmodule : led_scan_timer

// File: rtl/led_scan.sv
// led_scan: time-multiplexed driver for a 4x8 active-low LED matrix.
// Each column is selected for COL_CYCLES clocks; the row pattern is
// snapshotted at slot start and held for the whole slot (no tearing), with
// the first BLANK_CYCLES of each slot forced dark to suppress ghosting.
// Optional macro LEDSCAN_BRIGHTNESS_EN adds a 4-bit PWM brightness input
// (duty brightness/16 over the non-blanked part of the slot).
module led_scan
  import led_scan_pkg::*;
#(
  parameter int COL_CYCLES   = 3000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk12MHz,
  input  logic       reset,
  led_scan_if.slave  bus
);

  col_idx_t    col;
  logic [15:0] cnt;
  logic        slot_start;

  led_scan_timer #(
    .COL_CYCLES (COL_CYCLES)
  ) u_timer (
    .clk12MHz   (clk12MHz),
    .reset      (reset),
    .col        (col),
    .cnt        (cnt),
    .slot_start (slot_start)
  );

  // Holding registers indexed by column number.
  row_t pattern [NUM_COLS];
  assign pattern[0] = bus.leds1;
  assign pattern[1] = bus.leds2;
  assign pattern[2] = bus.leds3;
  assign pattern[3] = bus.leds4;

  // One-cold column select decode for the current column.
  col_sel_t lcol_next;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      assign lcol_next[gi] = (col != col_idx_t'(gi));
    end
  endgenerate

  // Blanking window at the head of each slot (none when BLANK_CYCLES==0).
  logic in_blank;
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYCLES);
      assign in_blank = (cnt < BLANK_LIM);
    end
  endgenerate

  row_t     snap_reg, snap_next;
  row_t     leds_reg, leds_next;
  col_sel_t lcol_reg;
  logic     pwm_on;

`ifdef LEDSCAN_BRIGHTNESS_EN
  logic [3:0] bright_reg, bright_next;
  logic [3:0] pwm_phase;

  // Brightness is captured alongside the snapshot so it stays constant per slot.
  always_comb begin
    bright_next = bright_reg;
    if (slot_start) begin
      bright_next = bus.brightness;
    end
  end

  // PWM phase restarts where blanking ends; mod 16 is just the low nibble.
  assign pwm_phase = cnt[3:0] - 4'(BLANK_CYCLES % 16);
  assign pwm_on    = (pwm_phase < bright_next);

  // Brightness register.
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      bright_reg <= 4'd0;
    end else begin
      bright_reg <= bright_next;
    end
  end
`else
  assign pwm_on = 1'b1;
`endif

  // Snapshot and row drive; the row register uses the freshly loaded
  // snapshot so a zero-length blank shows the new column immediately.
  always_comb begin
    snap_next = snap_reg;
    if (slot_start) begin
      snap_next = pattern[col];
    end
    leds_next = LEDS_OFF;
    if (!in_blank && pwm_on) begin
      leds_next = snap_next;
    end
  end

  // Output and snapshot registers; reset blanks everything.
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      snap_reg <= LEDS_OFF;
      leds_reg <= LEDS_OFF;
      lcol_reg <= LCOL_NONE;
    end else begin
      snap_reg <= snap_next;
      leds_reg <= leds_next;
      lcol_reg <= lcol_next;
    end
  end

  assign bus.leds = leds_reg;
  assign bus.lcol = lcol_reg;

endmodule : led_scan

// File: tb/tb_led_scan.sv
// tb_led_scan: self-checking bench for led_scan (COL_CYCLES=8,
// BLANK_CYCLES=2 main instance, plus a BLANK_CYCLES=0 instance and, with
// LEDSCAN_BRIGHTNESS_EN, a COL_CYCLES=34 brightness instance).
module tb_led_scan;
  import led_scan_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset0;
`ifdef LEDSCAN_BRIGHTNESS_EN
  logic reset_b;
`endif

  always #5 clk = ~clk;

  led_scan_if bus_a ();
  led_scan_if bus_z ();

  led_scan #(.COL_CYCLES(8), .BLANK_CYCLES(2)) u_dut (
    .clk12MHz (clk),
    .reset    (reset),
    .bus      (bus_a)
  );

  led_scan #(.COL_CYCLES(8), .BLANK_CYCLES(0)) u_dut0 (
    .clk12MHz (clk),
    .reset    (reset0),
    .bus      (bus_z)
  );

`ifdef LEDSCAN_BRIGHTNESS_EN
  led_scan_if bus_b ();
  led_scan #(.COL_CYCLES(34), .BLANK_CYCLES(2)) u_dutb (
    .clk12MHz (clk),
    .reset    (reset_b),
    .bus      (bus_b)
  );
`endif

  typedef struct {
    int       sel;
    col_sel_t lcol;
    row_t     leds;
    string    name;
  } exp_t;

  typedef struct {
    row_t     l1, l2, l3, l4;
    row_t     l2_mid;
    col_sel_t lcol;
    row_t     row;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(row_t l1, row_t l2, row_t l3, row_t l4,
                              row_t l2_mid, col_sel_t lcol, row_t row);
    vec_t v;
    v.l1 = l1; v.l2 = l2; v.l3 = l3; v.l4 = l4;
    v.l2_mid = l2_mid; v.lcol = lcol; v.row = row;
    return v;
  endfunction

  task automatic check_out();
    exp_t     e;
    col_sel_t act_lcol;
    row_t     act_leds;
    e = sb_q.pop_front();
    act_lcol = 'x;
    act_leds = 'x;
    case (e.sel)
      0: begin act_lcol = bus_a.lcol; act_leds = bus_a.leds; end
      1: begin act_lcol = bus_z.lcol; act_leds = bus_z.leds; end
`ifdef LEDSCAN_BRIGHTNESS_EN
      2: begin act_lcol = bus_b.lcol; act_leds = bus_b.leds; end
`endif
      default: ;
    endcase
    checks++;
    if (act_lcol !== e.lcol || act_leds !== e.leds) begin
      errors++;
      $display("FAIL %s: got lcol=%h leds=%h, expected lcol=%h leds=%h",
               e.name, act_lcol, act_leds, e.lcol, e.leds);
    end else begin
      $display("ok   %s: lcol=%h leds=%h", e.name, act_lcol, act_leds);
    end
  endtask

  // Push the expectation for the coming edge, then check after it; returns
  // at the next falling edge, where the caller drives new inputs.
  task automatic tick(input int sel, input col_sel_t lcol, input row_t leds,
                      input string name);
    exp_t e;
    e.sel = sel; e.lcol = lcol; e.leds = leds; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  vec_t vecs [14];

  initial begin
    row_t pat0 [4];

    // Slot table: two static frames, then the mid-slot leds2 update.
    for (int f = 0; f < 2; f++) begin
      vecs[f*4+0] = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h02, 4'hE, 8'h01);
      vecs[f*4+1] = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h02, 4'hD, 8'h02);
      vecs[f*4+2] = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h02, 4'hB, 8'h04);
      vecs[f*4+3] = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h02, 4'h7, 8'h08);
    end
    vecs[8]  = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h02, 4'hE, 8'h01);
    vecs[9]  = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'hA5, 4'hD, 8'h02);
    vecs[10] = mk(8'h01, 8'hA5, 8'h04, 8'h08, 8'hA5, 4'hB, 8'h04);
    vecs[11] = mk(8'h01, 8'hA5, 8'h04, 8'h08, 8'hA5, 4'h7, 8'h08);
    vecs[12] = mk(8'h01, 8'hA5, 8'h04, 8'h08, 8'hA5, 4'hE, 8'h01);
    vecs[13] = mk(8'h01, 8'hA5, 8'h04, 8'h08, 8'hA5, 4'hD, 8'hA5);

    reset  = 1'b1;
    reset0 = 1'b1;
    bus_a.leds1 = 8'h01; bus_a.leds2 = 8'h02;
    bus_a.leds3 = 8'h04; bus_a.leds4 = 8'h08;
    bus_z.leds1 = 8'h3C; bus_z.leds2 = 8'hC3;
    bus_z.leds3 = 8'h5A; bus_z.leds4 = 8'hFF;
`ifdef LEDSCAN_BRIGHTNESS_EN
    reset_b = 1'b1;
    bus_a.brightness = 4'd15;
    bus_z.brightness = 4'd15;
    bus_b.brightness = 4'd4;
    bus_b.leds1 = 8'h00; bus_b.leds2 = 8'h00;
    bus_b.leds3 = 8'h00; bus_b.leds4 = 8'h00;
`endif

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) tick(0, LCOL_NONE, LEDS_OFF, "reset_hold");
    reset = 1'b0;

    // Table-driven slots.
    for (int i = 0; i < 14; i++) begin
      bus_a.leds1 = vecs[i].l1; bus_a.leds2 = vecs[i].l2;
      bus_a.leds3 = vecs[i].l3; bus_a.leds4 = vecs[i].l4;
      for (int ph = 0; ph < 8; ph++) begin
        if (ph == 4) bus_a.leds2 = vecs[i].l2_mid;
        tick(0, vecs[i].lcol, (ph < 2) ? LEDS_OFF : vecs[i].row,
             $sformatf("scan_slot%0d_ph%0d", i, ph));
      end
    end

    // Reset asserted in column 3 at cnt=5.
    for (int ph = 0; ph < 5; ph++)
      tick(0, 4'hB, (ph < 2) ? LEDS_OFF : 8'h04, "col3_before_rst");
    reset = 1'b1;
    tick(0, LCOL_NONE, LEDS_OFF, "rst_mid_slot");
    tick(0, LCOL_NONE, LEDS_OFF, "rst_mid_slot_hold");
    reset = 1'b0;
    for (int ph = 0; ph < 8; ph++)
      tick(0, 4'hE, (ph < 2) ? LEDS_OFF : 8'h01, "restart_col1");
    for (int ph = 0; ph < 8; ph++)
      tick(0, 4'hD, (ph < 2) ? LEDS_OFF : 8'hA5, "restart_col2");

    // Zero blanking: pattern visible from the first cycle of every slot.
    pat0[0] = 8'h3C; pat0[1] = 8'hC3; pat0[2] = 8'h5A; pat0[3] = 8'hFF;
    tick(1, LCOL_NONE, LEDS_OFF, "blank0_reset");
    reset0 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      col_sel_t l;
      l = ~(col_sel_t'(1) << ((k / 8) % 4));
      tick(1, l, pat0[(k / 8) % 4], $sformatf("blank0_k%0d", k));
    end

`ifdef LEDSCAN_BRIGHTNESS_EN
    // Brightness 4/16 for one frame, then brightness 0 for one slot.
    tick(2, LCOL_NONE, LEDS_OFF, "bright_reset");
    reset_b = 1'b0;
    for (int k = 0; k < 136; k++) begin
      int       p;
      col_sel_t l;
      p = k % 34;
      l = ~(col_sel_t'(1) << ((k / 34) % 4));
      tick(2, l, (p >= 2 && ((p - 2) % 16) < 4) ? 8'h00 : LEDS_OFF,
           $sformatf("bright4_k%0d", k));
    end
    bus_b.brightness = 4'd0;
    for (int k = 0; k < 34; k++)
      tick(2, 4'hE, LEDS_OFF, $sformatf("bright0_k%0d", k));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_scan

// File: doc/led_scan.md
Name: led_scan

Overview:
- Time-multiplexed driver for a 4-column × 8-row LED matrix (iceFUN board).
- Four 8-bit holding registers are supplied by the parent; one column is shown at a time.
- The block cycles the columns continuously, with a short blanking gap at the start of each column slot to suppress ghosting.
- It sits between the top-level status logic (channel values, debug patterns) and the board's LED/column pins.

Parameters:
- COL_CYCLES, 3000: clock cycles each column stays selected. At 12 MHz this gives a 4 kHz column rate and a 1 kHz frame rate. Legal range is 2..65535.
- BLANK_CYCLES, 64: cycles at the start of each column slot during which all row outputs are forced off. Must satisfy 0 <= BLANK_CYCLES < COL_CYCLES.

Ports:
- clk12MHz, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- leds1, input, 8: row pattern for column 1. Active-low: 0 = LED lit.
- leds2, input, 8: row pattern for column 2. Active-low.
- leds3, input, 8: row pattern for column 3. Active-low.
- leds4, input, 8: row pattern for column 4. Active-low.
- leds, output, 8: row drive. Active-low; 8'hFF = all off.
- lcol, output, 4: column select. Active-low, one-cold; 4'hF = no column selected.
- brightness, input, 4: present only with LEDSCAN_BRIGHTNESS_EN (see Optional Feature).

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- All outputs are registered.
- State:
  - slot counter cnt, width 16, range 0..COL_CYCLES-1.
  - column index col, 2 bits.
  - 8-bit snapshot register snap.
- Reset:
  - cnt=0, col=0, snap=8'hFF.
  - Outputs: lcol=4'hF, leds=8'hFF.
  - Reset asserted mid-slot takes effect on the next edge. The scan restarts at column 0 with a full blanking period.
- Counter:
  - Each clock, cnt increments.
  - When cnt==COL_CYCLES-1, cnt wraps to 0 and col increments modulo 4 (sequence 0→1→2→3→0).
- Snapshot:
  - On the cycle cnt==0, snap loads the holding register for col (col 0→leds1 … col 3→leds4).
  - Input changes within a slot are not visible until that column's next slot. This prevents tearing.
- Outputs, registered one cycle after state (col, cnt):
  - lcol = ~(4'b0001 << col).
  - leds = 8'hFF while cnt < BLANK_CYCLES; otherwise leds = snap.
- Observable latency:
  - An input change reaches leds no earlier than the start of that column's next slot plus BLANK_CYCLES+1 cycles.
  - Worst case is 4·COL_CYCLES + BLANK_CYCLES + 1 cycles.
- Frame period is exactly 4·COL_CYCLES cycles.
- lcol always has exactly one bit low after the first post-reset cycle. It never shows two columns simultaneously.
- BLANK_CYCLES=0: no blanking. leds shows snap for the entire slot, starting one cycle after the snapshot.
- No handshake; the inputs are level-sampled.

Optional Feature:
- Macro: LEDSCAN_BRIGHTNESS_EN.
- With the macro defined:
  - A 4-bit brightness input is added.
  - Within the non-blanked part of each slot, leds = snap only while ((cnt - BLANK_CYCLES) mod 16) < brightness. Otherwise leds = 8'hFF.
  - brightness=0 gives a dark matrix; brightness=15 gives a 15/16 duty cycle.
  - brightness is sampled together with snap at cnt==0.
- Without the macro: no brightness port; full duty after blanking.

Decomposition:
- Shared package led_scan_pkg holds:
  - NUM_COLS=4 and ROW_BITS=8.
  - typedef col_idx_t (2-bit) and typedef row_t (8-bit).
  - LEDS_OFF=8'hFF and LCOL_NONE=4'hF.
- One natural sub-module, led_scan_timer: the slot counter and column index. It emits col and cnt plus a slot_start pulse.
- Snapshot, blanking and PWM logic stay in led_scan.

Test Plan (bench uses COL_CYCLES=8, BLANK_CYCLES=2 unless noted):
- Reset held 3 cycles, then released → lcol=4'hF and leds=8'hFF during reset. First slot shows lcol=4'hE; leds=8'hFF for 2 cycles after snapshot, then equals leds1.
- leds1..4 = 8'h01, 8'h02, 8'h04, 8'h08 (static) → lcol steps E, D, B, 7 every 8 cycles. leds shows 01/02/04/08 after each blanking gap. Frame = 32 cycles.
- Change leds2 from 8'h02 to 8'hA5 mid-slot of column 2 → current slot still shows 8'h02; the next column-2 slot shows 8'hA5.
- Assert reset during column 3, cnt=5 → next edge gives lcol=4'hF, leds=8'hFF. After release, scan restarts at column 1 (lcol=4'hE).
- BLANK_CYCLES=0 → leds never shows 8'hFF unless the pattern itself is 8'hFF; there is no gap between snapshot and display.
- LEDSCAN_BRIGHTNESS_EN, COL_CYCLES=34, BLANK_CYCLES=2, brightness=4, leds1=8'h00 → within column 1's slot, leds=8'h00 for 4 of every 16 non-blanked cycles. brightness=0 → leds stays 8'hFF.
